// File: rtl/smi_rx_mux.sv
// Multi-channel SMI read-side data mover: drains NUM_CH sample FIFOs MSB-first in BUS_W beats per SOE strobe.
// Optional build macro SMI_TEST_PATTERN_EN adds i_smi_test and per-channel counter test patterns.
module smi_rx_mux #(
   parameter int          NUM_CH  = 2,
   parameter int          WORD_W  = 32,
   parameter int          BUS_W   = 8,
   parameter int          ADDR_W  = 3,
   parameter logic [7:0]  VERSION = 8'h02
) (
   input  logic                     i_sys_clk,
   input  logic                     soe_and_reset,
   input  logic [4:0]               i_ioc,
   input  logic                     i_cs,
   input  logic                     i_fetch_cmd,
   output logic [7:0]               o_data_out,
   input  logic                     i_clr_err,
   input  logic [NUM_CH*WORD_W-1:0] i_fifo_data,
   input  logic [NUM_CH-1:0]        i_fifo_empty,
   input  logic [NUM_CH-1:0]        i_fifo_full,
   output logic [NUM_CH-1:0]        o_fifo_pull,
   input  logic [ADDR_W-1:0]        i_smi_a,
   input  logic                     i_smi_soe_se,
`ifdef SMI_TEST_PATTERN_EN
   input  logic                     i_smi_test,
`endif
   output logic [BUS_W-1:0]         o_smi_data_out,
   output logic                     o_smi_read_req,
   output logic [NUM_CH-1:0]        o_underrun
);

   typedef enum logic [1:0] {ST_IDLE, ST_PULL, ST_LOAD, ST_VALID} ch_state_t;

   localparam int               BEATS    = WORD_W / BUS_W;
   localparam int               IDX_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

   logic                soe_meta_q, soe_meta_d;
   logic                soe_sync_q, soe_sync_d;
   logic                soe_prev_q, soe_prev_d;
   logic                strb;
   logic [ADDR_W-2:0]   addr_l;
   logic [NUM_CH-1:0]   ch_sel;

   ch_state_t           state_q [NUM_CH];
   ch_state_t           state_d [NUM_CH];
   logic [WORD_W-1:0]   word_q  [NUM_CH];
   logic [WORD_W-1:0]   word_d  [NUM_CH];
   logic [IDX_W-1:0]    idx_q   [NUM_CH];
   logic [IDX_W-1:0]    idx_d   [NUM_CH];

   logic [BUS_W-1:0]    smi_data_q, smi_data_d;
   logic [NUM_CH-1:0]   underrun_q, underrun_d;
   logic [7:0]          data_out_q, data_out_d;
   logic [NUM_CH-1:0]   fifo_pull;
   logic [NUM_CH-1:0]   ch_valid;
   logic [7:0]          stat_pairs, stat_ur, stat_valid;
   logic                test_mode;

`ifdef SMI_TEST_PATTERN_EN
   logic [7:0]          cnt_q [NUM_CH];
   logic [7:0]          cnt_d [NUM_CH];
   assign test_mode = i_smi_test;
`else
   assign test_mode = 1'b0;
`endif

   // Strobe is the falling edge of the synchronised SOE; at most one channel is selected.
   always_comb begin
      soe_meta_d = i_smi_soe_se;
      soe_sync_d = soe_meta_q;
      soe_prev_d = soe_sync_q;
      strb       = soe_prev_q & ~soe_sync_q;
      addr_l     = i_smi_a[ADDR_W-2:0];
      for (int k = 0; k < NUM_CH; k++) begin
         ch_sel[k] = strb && i_smi_a[ADDR_W-1] && (int'(addr_l) == k + 1);
      end
   end

   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      smi_data_d = smi_data_q;
      underrun_d = i_clr_err ? '0 : underrun_q;
      fifo_pull  = '0;
      ch_valid   = '0;
`ifdef SMI_TEST_PATTERN_EN
      cnt_d      = cnt_q;
`endif
      for (int k = 0; k < NUM_CH; k++) begin
         state_d[k]  = state_q[k];
         word_d[k]   = word_q[k];
         idx_d[k]    = idx_q[k];
         ch_valid[k] = (state_q[k] == ST_VALID);
         if (test_mode) begin
`ifdef SMI_TEST_PATTERN_EN
            if (ch_sel[k]) begin
               smi_data_d = BUS_W'(cnt_q[k]);
               cnt_d[k]   = cnt_q[k] + 8'd1;
            end
`endif
         end else begin
            case (state_q[k])
               ST_IDLE: begin
                  if (!i_fifo_empty[k]) state_d[k] = ST_PULL;
               end
               ST_PULL: begin
                  fifo_pull[k] = 1'b1;
                  state_d[k]   = ST_LOAD;
               end
               ST_LOAD: begin
                  word_d[k]  = i_fifo_data[k*WORD_W +: WORD_W];
                  idx_d[k]   = '0;
                  state_d[k] = ST_VALID;
               end
               ST_VALID: begin
                  if (ch_sel[k]) begin
                     smi_data_d = word_q[k][WORD_W-1-int'(idx_q[k])*BUS_W -: BUS_W];
                     if (idx_q[k] == LAST_IDX) begin
                        idx_d[k]   = '0;
                        state_d[k] = ST_IDLE;
                     end else begin
                        idx_d[k] = idx_q[k] + 1'b1;
                     end
                  end
               end
               default: state_d[k] = ST_IDLE;
            endcase
            // A strobe before the word is usable returns zero and leaves the FSM alone.
            if (ch_sel[k] && (state_q[k] != ST_VALID)) begin
               smi_data_d    = '0;
               underrun_d[k] = 1'b1;
            end
         end
      end
   end

   always_comb begin
      stat_pairs = '0;
      stat_ur    = '0;
      stat_valid = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         stat_pairs[2*k]   = i_fifo_empty[k];
         stat_pairs[2*k+1] = i_fifo_full[k];
         stat_ur[k]        = underrun_q[k];
         stat_valid[k]     = ch_valid[k];
      end
      data_out_d = data_out_q;
      if (i_cs && i_fetch_cmd) begin
         case (i_ioc)
            5'd0:    data_out_d = VERSION;
            5'd1:    data_out_d = stat_pairs;
            5'd2:    data_out_d = stat_ur;
            5'd3:    data_out_d = stat_valid;
            default: data_out_d = data_out_q;
         endcase
      end
   end

   always_ff @(posedge i_sys_clk or negedge soe_and_reset) begin
      if (!soe_and_reset) begin
         soe_meta_q <= 1'b1;
         soe_sync_q <= 1'b1;
         soe_prev_q <= 1'b1;
         smi_data_q <= '0;
         underrun_q <= '0;
         data_out_q <= '0;
         // NOTE: the word registers are a handful of flops, so they are reset with everything else for deterministic state.
         for (int k = 0; k < NUM_CH; k++) begin
            state_q[k] <= ST_IDLE;
            word_q[k]  <= '0;
            idx_q[k]   <= '0;
`ifdef SMI_TEST_PATTERN_EN
            cnt_q[k]   <= '0;
`endif
         end
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         soe_meta_q <= soe_meta_d;
         soe_sync_q <= soe_sync_d;
         soe_prev_q <= soe_prev_d;
         smi_data_q <= smi_data_d;
         underrun_q <= underrun_d;
         data_out_q <= data_out_d;
         for (int k = 0; k < NUM_CH; k++) begin
            state_q[k] <= state_d[k];
            word_q[k]  <= word_d[k];
            idx_q[k]   <= idx_d[k];
`ifdef SMI_TEST_PATTERN_EN
            cnt_q[k]   <= cnt_d[k];
`endif
         end
      end
   end

   assign o_data_out     = data_out_q;
   assign o_smi_data_out = smi_data_q;
   assign o_underrun     = underrun_q;
   assign o_fifo_pull    = fifo_pull;
   assign o_smi_read_req = |ch_valid;

endmodule

// File: tb/tb_smi_rx_mux.sv
// Randomised scoreboard bench for smi_rx_mux: a queue-based channel model predicts each SMI beat,
// a separate monitor compares the registered beat and underrun flags after every strobe.
`timescale 1ns/1ps
module tb_smi_rx_mux;
   localparam int NUM_CH = 2;
   localparam int WORD_W = 32;
   localparam int BUS_W  = 8;
   localparam int ADDR_W = 3;
   localparam int DEPTH  = 256;

   typedef struct packed {
      logic [7:0] data;
      logic [1:0] ur;
   } exp_t;

   logic                     clk = 1'b0;
   logic                     rst_n = 1'b0;
   logic [4:0]               i_ioc = '0;
   logic                     i_cs = 1'b0;
   logic                     i_fetch_cmd = 1'b0;
   logic [7:0]               o_data_out;
   logic                     i_clr_err = 1'b0;
   logic [NUM_CH*WORD_W-1:0] i_fifo_data;
   logic [NUM_CH-1:0]        i_fifo_empty;
   logic [NUM_CH-1:0]        i_fifo_full = '0;
   logic [NUM_CH-1:0]        o_fifo_pull;
   logic [ADDR_W-1:0]        i_smi_a = '0;
   logic                     i_smi_soe_se = 1'b1;
   logic [BUS_W-1:0]         o_smi_data_out;
   logic                     o_smi_read_req;
   logic [NUM_CH-1:0]        o_underrun;
`ifdef SMI_TEST_PATTERN_EN
   logic                     i_smi_test = 1'b0;
`endif

   int n_checks = 0;
   int n_errors = 0;

   // FIFO emulation with one-cycle read latency; the stimulus thread owns wr, the pull process owns rd.
   logic [31:0] mem [NUM_CH][DEPTH];
   int          wr [NUM_CH] = '{default: 0};
   int          rd [NUM_CH] = '{default: 0};
   logic [31:0] fifo_rd [NUM_CH] = '{default: 32'h0};

   // Reference model state.
   logic [31:0] fifo_m [NUM_CH][$];
   logic [7:0]  cur [NUM_CH][$];
   logic [1:0]  ur_m = '0;
   logic [7:0]  last_m = '0;
   logic [7:0]  ctl_m = '0;
   logic [7:0]  cnt_m [NUM_CH] = '{default: 8'h0};
   bit          test_on = 1'b0;
   exp_t        sb[$];

   always #5 clk = ~clk;

   smi_rx_mux #(
      .NUM_CH(NUM_CH), .WORD_W(WORD_W), .BUS_W(BUS_W), .ADDR_W(ADDR_W), .VERSION(8'h02)
   ) dut (
      .i_sys_clk      (clk),
      .soe_and_reset  (rst_n),
      .i_ioc          (i_ioc),
      .i_cs           (i_cs),
      .i_fetch_cmd    (i_fetch_cmd),
      .o_data_out     (o_data_out),
      .i_clr_err      (i_clr_err),
      .i_fifo_data    (i_fifo_data),
      .i_fifo_empty   (i_fifo_empty),
      .i_fifo_full    (i_fifo_full),
      .o_fifo_pull    (o_fifo_pull),
      .i_smi_a        (i_smi_a),
      .i_smi_soe_se   (i_smi_soe_se),
`ifdef SMI_TEST_PATTERN_EN
      .i_smi_test     (i_smi_test),
`endif
      .o_smi_data_out (o_smi_data_out),
      .o_smi_read_req (o_smi_read_req),
      .o_underrun     (o_underrun)
   );

   always @(posedge clk) begin
      for (int k = 0; k < NUM_CH; k++) begin
         if (o_fifo_pull[k] && (rd[k] < wr[k])) begin
            fifo_rd[k] <= mem[k][rd[k] % DEPTH];
            rd[k]      <= rd[k] + 1;
         end
      end
   end

   always_comb begin
      for (int k = 0; k < NUM_CH; k++) begin
         i_fifo_data[k*WORD_W +: WORD_W] = fifo_rd[k];
         i_fifo_empty[k]                 = (wr[k] == rd[k]);
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic wait_neg(input int n);
      repeat (n) @(negedge clk);
   endtask

   // A loaded word becomes its byte list, most significant byte first.
   function automatic void refill();
      logic [31:0] w;
      for (int k = 0; k < NUM_CH; k++) begin
         if (cur[k].size() == 0 && fifo_m[k].size() > 0) begin
            w = fifo_m[k].pop_front();
            for (int b = 0; b < WORD_W / BUS_W; b++)
               cur[k].push_back(8'(w >> (BUS_W * (WORD_W / BUS_W - 1 - b))));
         end
      end
   endfunction

   task automatic push_word(input int k, input logic [31:0] w);
      mem[k][wr[k] % DEPTH] = w;
      wr[k]++;
      fifo_m[k].push_back(w);
      wait_neg(6);
      refill();
   endtask

   task automatic strobe(input logic [2:0] addr, input logic do_clr);
      exp_t e;
      int   k;
      if (do_clr) ur_m = '0;
      if (addr[2] && addr[1:0] != 2'd0 && int'(addr[1:0]) <= NUM_CH) begin
         k = int'(addr[1:0]) - 1;
         if (test_on) begin
            last_m   = cnt_m[k];
            cnt_m[k] = cnt_m[k] + 8'd1;
         end else if (cur[k].size() > 0) begin
            last_m = cur[k].pop_front();
         end else begin
            last_m  = 8'h00;
            ur_m[k] = 1'b1;
         end
      end
      e.data = last_m;
      e.ur   = ur_m;
      sb.push_back(e);
      @(negedge clk);
      i_smi_a      = addr;
      i_smi_soe_se = 1'b0;
      @(negedge clk);
      @(negedge clk);
      i_clr_err = do_clr;
      @(negedge clk);
      i_clr_err    = 1'b0;
      i_smi_soe_se = 1'b1;
      wait_neg(3);
      refill();
   endtask

   task automatic clr_pulse();
      @(negedge clk);
      i_clr_err = 1'b1;
      @(negedge clk);
      i_clr_err = 1'b0;
      ur_m      = '0;
      check("clr_underrun", 32'(o_underrun), 32'(ur_m));
   endtask

   task automatic ctl_read(input logic [4:0] ioc);
      logic [7:0] v;
      @(negedge clk);
      i_cs = 1'b1; i_fetch_cmd = 1'b1; i_ioc = ioc;
      v = '0;
      case (ioc)
         5'd0: ctl_m = 8'h02;
         5'd1: begin
            for (int k = 0; k < NUM_CH; k++) begin
               v[2*k]   = i_fifo_empty[k];
               v[2*k+1] = i_fifo_full[k];
            end
            ctl_m = v;
         end
         5'd2: ctl_m = 8'(ur_m);
         5'd3: begin
            for (int k = 0; k < NUM_CH; k++) v[k] = (cur[k].size() > 0);
            ctl_m = v;
         end
         default: ;
      endcase
      @(negedge clk);
      i_cs = 1'b0; i_fetch_cmd = 1'b0;
      check($sformatf("ctl_ioc%0d", ioc), 32'(o_data_out), 32'(ctl_m));
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_data_out"}, 32'(o_data_out), 32'h0);
      check({tag, "_smi_data"}, 32'(o_smi_data_out), 32'h0);
      check({tag, "_pull"}, 32'(o_fifo_pull), 32'h0);
      check({tag, "_underrun"}, 32'(o_underrun), 32'h0);
      check({tag, "_read_req"}, 32'(o_smi_read_req), 32'h0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
         cur[k].delete();
         cnt_m[k] = 8'h0;
      end
      ur_m   = '0;
      last_m = '0;
      ctl_m  = '0;
      wait_neg(1);
      check_reset_outputs("midrst");
      @(negedge clk);
      rst_n = 1'b1;
      wait_neg(6);
      refill();
   endtask

   // Monitor: each strobe's beat is registered three rising edges after SOE falls.
   initial begin
      exp_t e;
      forever begin
         @(negedge i_smi_soe_se);
         repeat (3) @(posedge clk);
         @(negedge clk);
         check("sb_pending", 32'(sb.size() > 0), 32'h1);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check("smi_data", 32'(o_smi_data_out), 32'(e.data));
            check("underrun", 32'(o_underrun), 32'(e.ur));
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int snap0, snap1;
      logic [2:0] a;
      wait_neg(3);
      check_reset_outputs("reset");
      rst_n = 1'b1;
      wait_neg(3);

      // Single word on ch0, a second word queued to show the refill.
      push_word(0, 32'hA1B2C3D4);
      check("t1_pull_once", 32'(rd[0]), 32'd1);
      check("t1_read_req", 32'(o_smi_read_req), 32'h1);
      push_word(0, $urandom);
      check("t1_no_extra_pull", 32'(rd[0]), 32'd1);
      repeat (4) strobe(3'b101, 1'b0);
      check("t1_refill", 32'(rd[0]), 32'd2);

      // Both channels loaded, interleaved random order.
      push_word(0, $urandom);
      push_word(1, $urandom);
      push_word(1, $urandom);
      repeat (16) strobe($urandom_range(0, 1) ? 3'b101 : 3'b110, 1'b0);

      // Underrun on ch1, clear, then clear coincident with a new underrun.
      while (cur[1].size() > 0 || fifo_m[1].size() > 0) strobe(3'b110, 1'b0);
      strobe(3'b110, 1'b0);
      clr_pulse();
      strobe(3'b110, 1'b1);
      clr_pulse();

      // Unmapped addresses leave data, pulls and flags untouched.
      snap0 = rd[0];
      snap1 = rd[1];
      strobe(3'b011, 1'b0);
      strobe(3'b111, 1'b0);
      strobe(3'b000, 1'b0);
      strobe(3'b100, 1'b0);
      check("t4_pull0", 32'(rd[0]), 32'(snap0));
      check("t4_pull1", 32'(rd[1]), 32'(snap1));

      // Control bus.
      i_fifo_full = 2'b10;
      ctl_read(5'd0);
      ctl_read(5'd1);
      push_word(1, $urandom);
      strobe(3'b110, 1'b0);
      strobe(3'b101, 1'b0);
      ctl_read(5'd2);
      ctl_read(5'd3);
      ctl_read(5'd5);
      i_fifo_full = 2'b01;
      ctl_read(5'd1);
      ctl_read(5'd31);
      i_fifo_full = '0;

      // Reset after two beats of a fresh word; the following word starts at its MSB.
      while (cur[0].size() > 0 || fifo_m[0].size() > 0) strobe(3'b101, 1'b0);
      push_word(0, 32'h11223344);
      strobe(3'b101, 1'b0);
      strobe(3'b101, 1'b0);
      do_reset();
      push_word(0, 32'h55667788);
      repeat (4) strobe(3'b101, 1'b0);

      // Random mix of pushes, strobes and clears.
      for (int i = 0; i < 60; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            a[0] = 1'($urandom_range(0, 1));
            if (fifo_m[a[0]].size() < 3) push_word(int'(a[0]), $urandom);
         end else begin
            a = 3'($urandom_range(0, 7));
            strobe(a, ($urandom_range(0, 7) == 0));
         end
      end

`ifdef SMI_TEST_PATTERN_EN
      snap0   = rd[0];
      snap1   = rd[1];
      test_on = 1'b1;
      @(negedge clk);
      i_smi_test = 1'b1;
      repeat (300) strobe(3'b101, 1'b0);
      check("t6_pull0", 32'(rd[0]), 32'(snap0));
      check("t6_pull1", 32'(rd[1]), 32'(snap1));
      @(negedge clk);
      i_smi_test = 1'b0;
      test_on    = 1'b0;
`endif

      wait_neg(10);
      for (int k = 0; k < NUM_CH; k++)
         check($sformatf("pull_total%0d", k), 32'(rd[k]), 32'(wr[k] - fifo_m[k].size()));
      check("sb_drained", 32'(sb.size()), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
